// File: rtl/click_cmd_sequencer_pkg.sv
// Shared encodings for the click command sequencer: action codes, command ops
// and FSM states.
package click_cmd_sequencer_pkg;

  typedef enum logic [2:0] {
    ACT_NONE    = 3'b000,
    ACT_BTNC    = 3'b001,
    ACT_DBLBTNC = 3'b010,
    ACT_UNDEF   = 3'b011,
    ACT_U       = 3'b100,
    ACT_R       = 3'b101,
    ACT_D       = 3'b110,
    ACT_L       = 3'b111
  } action_e;

  typedef enum logic {
    OP_REVEAL = 1'b0,
    OP_FLAG   = 1'b1
  } cmd_op_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_ACK     = 2'd2,
    S_RELEASE = 2'd3
  } state_e;

endpackage

// File: rtl/click_cmd_sequencer_if.sv
// Bundle of click-detector, board-engine and cursor signals around the sequencer;
// master is the sequencer side, slave the surrounding environment.
interface click_cmd_sequencer_if #(
  parameter int ROW_W = 3,
  parameter int COL_W = 3
);
  logic [2:0]       action;
  logic             game_over;
  logic             cmd_ready;
  logic             ack;
  logic             cmd_valid;
  logic             cmd_op;
  logic [ROW_W-1:0] cmd_row;
  logic [COL_W-1:0] cmd_col;
  logic [ROW_W-1:0] cursor_row;
  logic [COL_W-1:0] cursor_col;
  logic             busy;

  modport master (
    input  action, game_over, cmd_ready,
    output ack, cmd_valid, cmd_op, cmd_row, cmd_col, cursor_row, cursor_col, busy
  );

  modport slave (
    output action, game_over, cmd_ready,
    input  ack, cmd_valid, cmd_op, cmd_row, cmd_col, cursor_row, cursor_col, busy
  );
endinterface

// File: rtl/click_cmd_sequencer_wrap_counter.sv
// Modulo-N up/down counter used for one cursor axis; inc wins over dec if both
// are ever raised together.
module wrap_counter #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] value
);
  localparam logic [W-1:0] MAX = W'(N - 1);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (inc) begin
      value_d = (value_q == MAX) ? '0 : value_q + W'(1);
    end else if (dec) begin
      value_d = (value_q == '0) ? MAX : value_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
endmodule

// File: rtl/click_cmd_sequencer.sv
// Turns click-detector action codes into cursor moves or reveal/flag commands,
// then acknowledges the detector and waits for the button to be released.
module click_cmd_sequencer
  import click_cmd_sequencer_pkg::*;
#(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int ROW_W      = 3,
  parameter int COL_W      = 3,
  parameter int ACK_CYCLES = 2
) (
  input logic clk,
  input logic clear,
  click_cmd_sequencer_if.master bus
);
  localparam logic [3:0] ACK_LOAD = 4'(ACK_CYCLES - 1);

  state_e           state_q;
  logic             ack_q;
  logic [3:0]       ack_cnt_q;
  logic             cmd_valid_q;
  logic             cmd_op_q;
  logic [ROW_W-1:0] cmd_row_q;
  logic [COL_W-1:0] cmd_col_q;
  logic             busy_q;

  logic             row_inc, row_dec, col_inc, col_dec;
  logic [ROW_W-1:0] cur_row;
  logic [COL_W-1:0] cur_col;

  // Cursor steps only on the edge that leaves IDLE with an arrow action.
  always_comb begin
    row_inc = 1'b0;
    row_dec = 1'b0;
    col_inc = 1'b0;
    col_dec = 1'b0;
    if (state_q == S_IDLE) begin
      case (bus.action)
        ACT_U:   row_dec = 1'b1;
        ACT_D:   row_inc = 1'b1;
        ACT_L:   col_dec = 1'b1;
        ACT_R:   col_inc = 1'b1;
        default: ;
      endcase
    end
  end

  wrap_counter #(.N(ROWS), .W(ROW_W)) u_row (
    .clk   (clk),
    .clear (clear),
    .inc   (row_inc),
    .dec   (row_dec),
    .value (cur_row)
  );

  wrap_counter #(.N(COLS), .W(COL_W)) u_col (
    .clk   (clk),
    .clear (clear),
    .inc   (col_inc),
    .dec   (col_dec),
    .value (cur_col)
  );

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q     <= S_IDLE;
      ack_q       <= 1'b0;
      ack_cnt_q   <= '0;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= OP_REVEAL;
      cmd_row_q   <= '0;
      cmd_col_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.action != ACT_NONE) begin
            busy_q <= 1'b1;
            if ((bus.action == ACT_BTNC || bus.action == ACT_DBLBTNC) && !bus.game_over) begin
              cmd_row_q   <= cur_row;
              cmd_col_q   <= cur_col;
              cmd_op_q    <= bus.action[1];
              cmd_valid_q <= 1'b1;
              state_q     <= S_ISSUE;
            end else begin
              // Moves, locked-board clicks and the undefined code all just ack.
              ack_q     <= 1'b1;
              ack_cnt_q <= ACK_LOAD;
              state_q   <= S_ACK;
            end
          end
        end
        S_ISSUE: begin
          if (bus.cmd_ready) begin
            cmd_valid_q <= 1'b0;
            ack_q       <= 1'b1;
            ack_cnt_q   <= ACK_LOAD;
            state_q     <= S_ACK;
          end
        end
        S_ACK: begin
          if (ack_cnt_q == '0) begin
            ack_q   <= 1'b0;
            state_q <= S_RELEASE;
          end else begin
            ack_cnt_q <= ack_cnt_q - 4'd1;
          end
        end
        S_RELEASE: begin
          if (bus.action == ACT_NONE) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ack        = ack_q;
  assign bus.cmd_valid  = cmd_valid_q;
  assign bus.cmd_op     = cmd_op_q;
  assign bus.cmd_row    = cmd_row_q;
  assign bus.cmd_col    = cmd_col_q;
  assign bus.cursor_row = cur_row;
  assign bus.cursor_col = cur_col;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_click_cmd_sequencer.sv
// Directed and randomized bench for click_cmd_sequencer against a per-press
// behavioural model of the cursor, command and acknowledge behaviour.
module tb_click_cmd_sequencer;
  localparam int ROWS       = 8;
  localparam int COLS       = 8;
  localparam int ROW_W      = 3;
  localparam int COL_W      = 3;
  localparam int ACK_CYCLES = 2;

  logic clk = 1'b0;
  logic clear;
  int   checks = 0;
  int   passes = 0;

  click_cmd_sequencer_if #(.ROW_W(ROW_W), .COL_W(COL_W)) bus ();

  click_cmd_sequencer #(
    .ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W), .ACK_CYCLES(ACK_CYCLES)
  ) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // Model: a press either becomes a pending command or an ack burst, after
  // which the button has to be seen released before the next press counts.
  int mRow = 0, mCol = 0, mAckLeft = 0, mOp = 0, mCR = 0, mCC = 0;
  bit mPending = 0, mWaitRelease = 0, mStarted = 0;

  always @(posedge clk) begin
    if (clear) begin
      mRow = 0; mCol = 0; mAckLeft = 0; mOp = 0; mCR = 0; mCC = 0;
      mPending = 0; mWaitRelease = 0; mStarted = 1;
    end else if (mPending) begin
      if (bus.cmd_ready) begin
        mPending = 0;
        mAckLeft = ACK_CYCLES;
      end
    end else if (mAckLeft > 0) begin
      mAckLeft--;
      if (mAckLeft == 0) mWaitRelease = 1;
    end else if (mWaitRelease) begin
      if (bus.action == 3'b000) mWaitRelease = 0;
    end else begin
      case (bus.action)
        3'b000: ;
        3'b100: begin mRow = (mRow + ROWS - 1) % ROWS; mAckLeft = ACK_CYCLES; end
        3'b110: begin mRow = (mRow + 1) % ROWS;        mAckLeft = ACK_CYCLES; end
        3'b111: begin mCol = (mCol + COLS - 1) % COLS; mAckLeft = ACK_CYCLES; end
        3'b101: begin mCol = (mCol + 1) % COLS;        mAckLeft = ACK_CYCLES; end
        3'b001, 3'b010: begin
          if (bus.game_over) begin
            mAckLeft = ACK_CYCLES;
          end else begin
            mPending = 1;
            mOp = (bus.action == 3'b010) ? 1 : 0;
            mCR = mRow;
            mCC = mCol;
          end
        end
        default: mAckLeft = ACK_CYCLES;
      endcase
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  always @(negedge clk) begin
    if (mStarted && !clear) begin
      checkOutput("model_ack", int'(bus.ack), (mAckLeft > 0) ? 1 : 0);
      checkOutput("model_cmd_valid", int'(bus.cmd_valid), int'(mPending));
      checkOutput("model_busy", int'(bus.busy),
                  (mPending || mAckLeft > 0 || mWaitRelease) ? 1 : 0);
      checkOutput("model_cursor_row", int'(bus.cursor_row), mRow);
      checkOutput("model_cursor_col", int'(bus.cursor_col), mCol);
      checkOutput("model_cmd_op", int'(bus.cmd_op), mOp);
      checkOutput("model_cmd_row", int'(bus.cmd_row), mCR);
      checkOutput("model_cmd_col", int'(bus.cmd_col), mCC);
    end
  end

  task automatic applyStimulus(input logic [2:0] a, input logic go, input logic rdy);
    @(negedge clk);
    bus.action    = a;
    bus.game_over = go;
    bus.cmd_ready = rdy;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) checkOutput("idle_timeout", 1, 0);
  endtask

  task automatic press(input logic [2:0] a, input logic go);
    applyStimulus(a, go, 1'b1);
    applyStimulus(3'b000, go, 1'b1);
    waitIdle();
  endtask

  task automatic doClear();
    @(negedge clk);
    clear = 1'b1;
    bus.action = 3'b000;
    @(negedge clk);
    clear = 1'b0;
  endtask

  logic [2:0] act;
  int         hold;

  initial begin
    clear = 1'b1;
    bus.action = 3'b000;
    bus.game_over = 1'b0;
    bus.cmd_ready = 1'b0;
    repeat (2) @(negedge clk);
    clear = 1'b0;
    checkOutput("reset_row", int'(bus.cursor_row), 0);
    checkOutput("reset_col", int'(bus.cursor_col), 0);
    checkOutput("reset_busy", int'(bus.busy), 0);
    checkOutput("reset_ack", int'(bus.ack), 0);
    checkOutput("reset_valid", int'(bus.cmd_valid), 0);

    // Right move: cursor and ack one cycle after sampling, ack two cycles wide.
    applyStimulus(3'b101, 1'b0, 1'b1);
    applyStimulus(3'b000, 1'b0, 1'b1);
    checkOutput("r_col", int'(bus.cursor_col), 1);
    checkOutput("r_ack0", int'(bus.ack), 1);
    @(negedge clk);
    checkOutput("r_ack1", int'(bus.ack), 1);
    @(negedge clk);
    checkOutput("r_ack2", int'(bus.ack), 0);
    waitIdle();
    checkOutput("r_busy", int'(bus.busy), 0);

    doClear();
    press(3'b100, 1'b0);
    checkOutput("wrap_row", int'(bus.cursor_row), 7);
    press(3'b111, 1'b0);
    checkOutput("wrap_col", int'(bus.cursor_col), 7);

    doClear();
    repeat (3) press(3'b110, 1'b0);
    repeat (5) press(3'b101, 1'b0);
    checkOutput("pos_row", int'(bus.cursor_row), 3);
    checkOutput("pos_col", int'(bus.cursor_col), 5);

    // Reveal at (3,5) with the engine stalling for four cycles.
    applyStimulus(3'b001, 1'b0, 1'b0);
    applyStimulus(3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("click_valid", int'(bus.cmd_valid), 1);
      checkOutput("click_op", int'(bus.cmd_op), 0);
      checkOutput("click_row", int'(bus.cmd_row), 3);
      checkOutput("click_col", int'(bus.cmd_col), 5);
      checkOutput("click_ack_low", int'(bus.ack), 0);
      if (i < 4) @(negedge clk);
    end
    bus.cmd_ready = 1'b1;
    @(negedge clk);
    checkOutput("accept_valid", int'(bus.cmd_valid), 0);
    checkOutput("accept_ack", int'(bus.ack), 1);
    waitIdle();

    // Locked board: double click dropped, moves still work.
    applyStimulus(3'b010, 1'b1, 1'b1);
    applyStimulus(3'b000, 1'b1, 1'b1);
    checkOutput("locked_valid", int'(bus.cmd_valid), 0);
    checkOutput("locked_ack", int'(bus.ack), 1);
    waitIdle();
    checkOutput("locked_row", int'(bus.cursor_row), 3);
    checkOutput("locked_col", int'(bus.cursor_col), 5);
    press(3'b100, 1'b1);
    checkOutput("locked_move", int'(bus.cursor_row), 2);

    // Held button moves only once until released.
    applyStimulus(3'b110, 1'b0, 1'b1);
    repeat (9) @(negedge clk);
    checkOutput("hold_row", int'(bus.cursor_row), 3);
    applyStimulus(3'b000, 1'b0, 1'b1);
    waitIdle();
    checkOutput("hold_row_after", int'(bus.cursor_row), 3);
    press(3'b110, 1'b0);
    checkOutput("repress_row", int'(bus.cursor_row), 4);

    // Clear mid-handshake.
    applyStimulus(3'b001, 1'b0, 1'b0);
    applyStimulus(3'b000, 1'b0, 1'b0);
    checkOutput("pre_clear_valid", int'(bus.cmd_valid), 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checkOutput("clr_valid", int'(bus.cmd_valid), 0);
    checkOutput("clr_ack", int'(bus.ack), 0);
    checkOutput("clr_row", int'(bus.cursor_row), 0);
    checkOutput("clr_col", int'(bus.cursor_col), 0);
    checkOutput("clr_busy", int'(bus.busy), 0);

    act  = 3'b000;
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (hold == 0) begin
        act  = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
        hold = int'($urandom_range(1, 6));
      end
      hold--;
      bus.action    = act;
      bus.game_over = ($urandom_range(0, 4) == 0);
      bus.cmd_ready = 1'($urandom_range(0, 1));
      clear         = ($urandom_range(0, 199) == 0);
    end
    @(negedge clk);
    clear = 1'b0;
    bus.action = 3'b000;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
